// File: rtl/base_skid_stage.sv
// Two-entry valid/ready skid stage: registered upstream ready, direct-enable main register,
// one-beat skid register that absorbs the in-flight beat when downstream stalls.
module base_skid_stage #(
    parameter int                 width = 1,
    parameter logic [0:width-1]   rstv  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_v,
    output logic               i_r,
    input  logic [0:width-1]   i_d,
    output logic               o_v,
    input  logic               o_r,
    output logic [0:width-1]   o_d,
    output logic [0:1]         o_occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               ready_q;
    logic               accept;
    logic               take;
    logic               main_load;
    logic               skid_load;
    logic [0:width-1]   main_next;
    logic [0:width-1]   main_q;
    logic [0:width-1]   skid_q;

    assign accept = i_v & ready_q;
    assign take   = o_v & o_r;
    assign i_r    = ready_q;
    assign o_d    = main_q;

    // Ready is a flop driven from next_state so o_r never reaches i_r combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (accept) next_state = ONE;
            end
            ONE: begin
                if (accept && !take)      next_state = TWO;
                else if (!accept && take) next_state = EMPTY;
            end
            TWO: begin
                if (take) next_state = ONE;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        o_v   = 1'b0;
        o_occ = 2'd0;
        case (state)
            ONE: begin
                o_v   = 1'b1;
                o_occ = 2'd1;
            end
            TWO: begin
                o_v   = 1'b1;
                o_occ = 2'd2;
            end
            default: begin
                o_v   = 1'b0;
                o_occ = 2'd0;
            end
        endcase
    end

    // Main loads from input on accept into an empty/draining stage, or from skid when TWO drains.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_next = i_d;
        case (state)
            EMPTY: main_load = accept;
            ONE: begin
                main_load = accept & take;
                skid_load = accept & ~take;
            end
            TWO: begin
                main_load = take;
                main_next = skid_q;
            end
            default: begin
                main_load = 1'b0;
                skid_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= rstv;
            skid_q <= rstv;
        end else begin
            if (main_load) main_q <= main_next;
            if (skid_load) skid_q <= i_d;
        end
    end

endmodule

// File: tb/tb_base_skid_stage.sv
// Scoreboard bench for base_skid_stage: a two-deep FIFO model of held beats, directed
// scenarios followed by randomized traffic with occasional resets.
module tb_base_skid_stage;

    localparam int         W    = 8;
    localparam logic [0:7] RSTV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_v;
    logic         i_r;
    logic [0:7]   i_d;
    logic         o_v;
    logic         o_r;
    logic [0:7]   o_d;
    logic [0:1]   o_occ;

    base_skid_stage #(.width(W), .rstv(RSTV)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_occ (o_occ)
    );

    always #5 clk = ~clk;

    logic [0:7] exp_q[$];
    logic       exp_ready = 1'b0;
    logic [0:7] last_out  = RSTV;
    bit         checking  = 1'b0;
    int         n_cmp     = 0;
    int         n_bad     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update at the active edge: accepted beats join the tail of the held queue.
    always @(posedge clk) begin
        checking = 1'b1;
        if (reset) begin
            exp_q.delete();
            exp_ready = 1'b0;
            last_out  = RSTV;
        end else begin
            if (i_v && exp_ready) exp_q.push_back(i_d);
            exp_ready = (exp_q.size() != 2);
        end
    end

    // Monitor away from the edge: compare, then retire the head if downstream takes it.
    always @(negedge clk) begin
        if (checking) begin
            check("o_v", {31'd0, o_v}, {31'd0, exp_q.size() != 0});
            check("o_occ", {30'd0, o_occ}, exp_q.size());
            check("i_r", {31'd0, i_r}, {31'd0, exp_ready});
            if (exp_q.size() != 0) begin
                check("o_d_head", {24'd0, o_d}, {24'd0, exp_q[0]});
                if (o_r) last_out = exp_q.pop_front();
            end else begin
                check("o_d_idle", {24'd0, o_d}, {24'd0, last_out});
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [0:7] d, input logic rr);
        reset = rst;
        i_v   = v;
        i_d   = d;
        o_r   = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_v   = 1'b1;
        i_d   = 8'h77;
        o_r   = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h77, 1'b0);

        // single beat
        drive(1'b0, 1'b1, 8'h5A, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // back-to-back streaming
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // backpressure into the skid register
        drive(1'b0, 1'b1, 8'h10, 1'b1);
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h12, 1'b0);
        drive(1'b0, 1'b1, 8'h12, 1'b1);
        drive(1'b0, 1'b1, 8'h12, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);

        // simultaneous accept and take in ONE
        drive(1'b0, 1'b1, 8'h20, 1'b0);
        drive(1'b0, 1'b1, 8'h21, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // reset while two beats are held
        drive(1'b0, 1'b1, 8'h30, 1'b0);
        drive(1'b0, 1'b1, 8'h31, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h32, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // randomized traffic with rare resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/base_skid_stage.md
Name: base_skid_stage

Overview:
- Two-entry valid/ready pipeline stage with a registered ready. It breaks the combinational ready path between a producer and the enabled data registers downstream.
- The main data register loads only when a beat is accepted or moved forward, so it maps to a direct-enable register.
- It is placed in front of `base_vlat_en`-style holding registers in the AFU datapath. It sustains one beat per cycle under steady flow and absorbs one beat when `o_r` drops.

Parameters:
- `width`, 1: data bits, bit-ordered [0:width-1].
- `rstv`, 0: [0:width-1] reset value loaded into both data registers.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_v`  in  1  upstream beat valid.
- `i_r`  out  1  upstream ready; registered, no combinational path from `o_r`.
- `i_d`  in  [0:width-1]  upstream data.
- `o_v`  out  1  downstream valid.
- `o_r`  in  1  downstream ready.
- `o_d`  out  [0:width-1]  downstream data; always the main register.
- `o_occ`  out  [0:1]  occupancy: 0, 1 or 2 beats held.

Behaviour:
- Definitions: accept = `i_v` & `i_r`; take = `o_v` & `o_r`.
- All state updates on posedge `clk`. Reset is synchronous and active-high: it is sampled only at the clock edge and overrides all other updates in that cycle.
- Reset values:
  - state = EMPTY, `o_v`=0, `o_occ`=0.
  - `i_r`=0 while `reset` is sampled high; `i_r`=1 on the first edge after `reset` is sampled low.
  - Main and skid registers = `rstv`.
- States: EMPTY (`o_v`=0, `i_r`=1), ONE (`o_v`=1, `i_r`=1), TWO (`o_v`=1, `i_r`=0).
- EMPTY transitions:
  - accept -> ONE, main <= `i_d`.
  - otherwise hold.
- ONE transitions:
  - accept & take -> ONE, main <= `i_d` (full throughput, zero bubbles).
  - accept & !take -> TWO, skid <= `i_d`, main unchanged.
  - !accept & take -> EMPTY.
  - neither -> hold.
- TWO transitions:
  - take -> ONE, main <= skid.
  - otherwise hold. No accept is possible since `i_r`=0.
- `i_r` is a flop: next value = (next state != TWO).
- Latency: `i_d` accepted in EMPTY appears on `o_d` with `o_v`=1 in the next cycle (1-cycle latency).
- Ordering is strict FIFO. The skid beat is always older than any later input.
- Data registers change only on their load condition; they hold otherwise, including in EMPTY. `o_d` is don't-care when `o_v`=0 but deterministic: the last loaded value, or `rstv`.
- `i_d` is ignored when accept=0. `i_v` may deassert without accept; no upstream persistence checking.
- `o_r` may be asserted with `o_v`=0; this has no effect.
- Reset mid-operation: held beats are discarded, with no output valid the following cycle.
- `o_occ` = 0/1/2 for EMPTY/ONE/TWO, registered with the state.

Test Plan:
- Reset: hold `reset`=1 3 cycles with `i_v`=1 -> `o_v`=0, `i_r`=0, `o_d`=`rstv`; on the first edge after `reset` drops, `i_r`=1.
- Single beat, `width`=8: `i_v`=1, `i_d`=0x5A for 1 cycle, `o_r`=1 -> next cycle `o_v`=1, `o_d`=0x5A, `o_occ`=1; following cycle `o_v`=0.
- Streaming: `o_r`=1, 16 back-to-back beats 0x00..0x0F -> `i_r` stays 1, outputs 0x00..0x0F on consecutive cycles, no gaps.
- Backpressure: stream 0x10,0x11,0x12 with `o_r`=0 from the cycle 0x10 is output -> 0x11 lands in skid, `o_occ`=2, `i_r`=0; 0x12 is held upstream. Raising `o_r` yields 0x10, 0x11, 0x12 in order.
- Simultaneous accept+take in ONE: main=0x20, present 0x21 with `o_r`=1 -> next cycle `o_d`=0x21, `o_occ`=1, skid untouched.
- Reset mid-operation in TWO (0x30, 0x31 held) -> after reset `o_v`=0, `o_occ`=0; 0x30/0x31 are never output; the next accepted beat 0x32 appears alone.
